// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen: 480x272 RGB-LCD raster timing with PLL-lock qualification
// Ports: clk pixel clock; reset async active-high; pll_locked raw PLL lock (async);
//        disp_en panel enable (RUN only); hsync/vsync active-low syncs; de data enable;
//        x/y pixel coordinates (0 outside de); line_start/frame_start one-clock strobes.
module lcd_timing_gen #(
  parameter int H_ACTIVE  = 480,
  parameter int H_FP      = 2,
  parameter int H_SYNC    = 41,
  parameter int H_BP      = 2,
  parameter int V_ACTIVE  = 272,
  parameter int V_FP      = 2,
  parameter int V_SYNC    = 10,
  parameter int V_BP      = 2,
  parameter int LOCK_WAIT = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_locked,
  output logic       disp_en,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic [9:0] x,
  output logic [8:0] y,
  output logic       line_start,
  output logic       frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int SW = $clog2(LOCK_WAIT + 1);
  typedef enum logic [1:0] {IDLE, SETTLE, RUN} state_t;
  state_t state_q, state_d;
  logic [1:0] sync_q;
  logic [SW-1:0] settle_q, settle_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic lock_s, run, h_last, v_last, act, hs_win, vs_win;
  assign lock_s = sync_q[1];
  assign run    = state_q == RUN;
  assign h_last = hcnt_q == HW'(H_TOTAL - 1);
  assign v_last = vcnt_q == VW'(V_TOTAL - 1);
  assign act    = hcnt_q < HW'(H_ACTIVE) && vcnt_q < VW'(V_ACTIVE);
  assign hs_win = hcnt_q >= HW'(H_ACTIVE + H_FP) && hcnt_q <= HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  assign vs_win = vcnt_q >= VW'(V_ACTIVE + V_FP) && vcnt_q <= VW'(V_ACTIVE + V_FP + V_SYNC - 1);
  // Counters default to 0 so IDLE, SETTLE and the RUN exit all leave the raster at (0,0).
  always_comb begin
    state_d  = state_q;
    settle_d = '0;
    hcnt_d   = '0;
    vcnt_d   = '0;
    case (state_q)
      IDLE:    state_d = lock_s ? SETTLE : IDLE;
      SETTLE: begin
        state_d  = !lock_s ? IDLE : (settle_q == SW'(LOCK_WAIT - 1)) ? RUN : SETTLE;
        settle_d = (lock_s && settle_q != SW'(LOCK_WAIT - 1)) ? settle_q + SW'(1) : '0;
      end
      RUN: begin
        state_d = lock_s ? RUN : IDLE;
        hcnt_d  = (!lock_s || h_last) ? '0 : hcnt_q + HW'(1);
        vcnt_d  = !lock_s ? '0 : !h_last ? vcnt_q : v_last ? '0 : vcnt_q + VW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      sync_q   <= '0;
      settle_q <= '0;
      hcnt_q   <= '0;
      vcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      sync_q   <= {sync_q[0], pll_locked};
      settle_q <= settle_d;
      hcnt_q   <= hcnt_d;
      vcnt_q   <= vcnt_d;
    end
  end
  // Outputs are decoded from the current state/counters and registered, so every
  // output lags the raster counters by exactly one clock; non-RUN forces reset values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_en     <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      disp_en     <= run;
      hsync       <= !(run && hs_win);
      vsync       <= !(run && vs_win);
      de          <= run && act;
      x           <= (run && act) ? 10'(hcnt_q) : '0;
      y           <= (run && act) ? 9'(vcnt_q) : '0;
      line_start  <= run && hcnt_q == '0;
      frame_start <= run && hcnt_q == '0 && vcnt_q == '0;
    end
  end
endmodule

// File: tb/tb_lcd_timing_gen.sv
// tb_lcd_timing_gen: directed check of lcd_timing_gen using a reduced raster
module tb_lcd_timing_gen;
  localparam int HA = 16, HF = 2, HS = 4, HB = 2;
  localparam int VA = 8, VF = 2, VS = 3, VB = 2;
  localparam int LW = 16;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam logic [24:0] IDLE_V = {1'b0, 1'b1, 1'b1, 1'b0, 10'd0, 9'd0, 1'b0, 1'b0};
  logic clk = 1'b0, reset = 1'b1, pll_locked = 1'b1;
  logic disp_en, hsync, vsync, de, line_start, frame_start;
  logic [9:0] x;
  logic [8:0] y;
  int tests = 0, fails = 0;
  int n, per, vlow, vfirst, decnt, deblank, lx, ly, hde, hlow, hfirst, ls_mid, mx;
  bit ok, seen;
  lcd_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .LOCK_WAIT(LW)
  ) dut (
    .clk(clk), .reset(reset), .pll_locked(pll_locked), .disp_en(disp_en),
    .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y),
    .line_start(line_start), .frame_start(frame_start)
  );
  always #5 clk = ~clk;
  function automatic logic [24:0] outs();
    return {disp_en, hsync, vsync, de, x, y, line_start, frame_start};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask
  task automatic wait_rise(output int cnt);
    cnt = 0;
    while (disp_en !== 1'b1 && cnt < 1000) begin
      @(negedge clk);
      cnt++;
    end
  endtask
  task automatic wait_xy(input int wx, input int wy, output bit hit);
    int k = 0;
    while (!(de === 1'b1 && x == 10'(wx) && y == 9'(wy)) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    hit = k < 2000;
  endtask
  task automatic measure_frame(output int p, output int vl, output int vf, output int dc,
                               output int db, output int ax, output int ay);
    p = 0; vl = 0; vf = -1; dc = 0; db = 0; ax = 0; ay = 0;
    do begin
      if (vsync === 1'b0) begin
        vl++;
        if (vf < 0) vf = p;
      end
      if (de === 1'b1) begin
        dc++;
        ax = int'(x);
        ay = int'(y);
        if (p / HT >= VA) db++;
      end
      @(negedge clk);
      p++;
    end while (frame_start !== 1'b1 && p < 2000);
  endtask
  task automatic check_start(input string tag);
    chk({tag, "_fs"}, 32'(frame_start), 32'd1);
    chk({tag, "_xy"}, 32'({x, y}), 32'd0);
    chk({tag, "_de_ls"}, 32'({de, line_start}), 32'b11);
  endtask
  initial begin
    tick(3);
    chk("reset_outputs", 32'(outs()), 32'(IDLE_V));
    reset = 1'b0;
    wait_rise(n);
    chk("lock_to_run_latency", n, LW + 4);
    check_start("first_run");
    hde = 0; hlow = 0; hfirst = -1; ls_mid = 0; mx = 0;
    for (int i = 0; i < HT; i++) begin
      if (de === 1'b1) begin
        hde++;
        mx = int'(x);
      end
      if (hsync === 1'b0) begin
        hlow++;
        if (hfirst < 0) hfirst = i;
      end
      if (i > 0 && line_start === 1'b1) ls_mid++;
      @(negedge clk);
    end
    chk("h_de_width", hde, HA);
    chk("h_last_x", mx, HA - 1);
    chk("hsync_width", hlow, HS);
    chk("hsync_offset", hfirst, HA + HF);
    chk("line_start_gap", ls_mid, 0);
    chk("line_start_period", 32'(line_start), 32'd1);
    chk("line1_y", 32'(y), 32'd1);
    n = 0;
    while (frame_start !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("frame_start_found", 32'(n < 2000), 32'd1);
    for (int f = 0; f < 2; f++) begin
      measure_frame(per, vlow, vfirst, decnt, deblank, lx, ly);
      chk($sformatf("frame%0d_period", f), per, HT * VT);
      chk($sformatf("frame%0d_vsync_width", f), vlow, VS * HT);
      chk($sformatf("frame%0d_vsync_start", f), vfirst, (VA + VF) * HT);
      chk($sformatf("frame%0d_de_count", f), decnt, HA * VA);
      chk($sformatf("frame%0d_de_in_vblank", f), deblank, 0);
      chk($sformatf("frame%0d_last_pixel", f), 32'({lx[15:0], ly[15:0]}), {16'(HA - 1), 16'(VA - 1)});
    end
    wait_xy(5, 3, ok);
    chk("reach_x5_y3", 32'(ok), 32'd1);
    pll_locked = 1'b0;
    tick(4);
    chk("lock_loss_outputs", 32'(outs()), 32'(IDLE_V));
    pll_locked = 1'b1;
    wait_rise(n);
    chk("relock_latency", n, LW + 4);
    check_start("relock");
    pll_locked = 1'b0;
    tick(6);
    chk("drop_again_idle", 32'(outs()), 32'(IDLE_V));
    pll_locked = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      seen |= disp_en;
    end
    pll_locked = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      seen |= disp_en;
    end
    pll_locked = 1'b1;
    chk("settle_abort_no_enable", 32'(seen), 32'd0);
    wait_rise(n);
    chk("settle_restart_latency", n, LW + 4);
    check_start("settle_restart");
    wait_xy(3, 5, ok);
    chk("reach_y5", 32'(ok), 32'd1);
    #2 reset = 1'b1;
    #1 chk("async_reset_outputs", 32'(outs()), 32'(IDLE_V));
    @(negedge clk);
    chk("reset_held_outputs", 32'(outs()), 32'(IDLE_V));
    reset = 1'b0;
    wait_rise(n);
    chk("post_reset_latency", n, LW + 4);
    check_start("post_reset");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
